// File: rtl/router_pkg.sv
// Shared router definitions: flit width, virtual-channel identifiers and flit type.
package router_pkg;

  localparam int   FLIT_W  = 64;
  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/rr_arb_n.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps.
// It produces a one-hot grant, an any-grant flag and the encoded winner index.
module rr_arb_n #(
  parameter  int NUM_IN = 4,
  localparam int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NUM_IN-1:0] gnt_o,
  output logic              any_o,
  output logic [PTR_W-1:0]  idx_o
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = PTR_W'((int'(ptr_i) + k) % NUM_IN);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/vc_output_ctrl.sv
// Output-port controller with two single-entry VC buffers. On each phase the buffer for
// VC p is loaded from the inputs while the buffer for VC ~p is drained onto the link.
module vc_output_ctrl
  import router_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int DATA_W = FLIT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     polarity,
  input  logic [NUM_IN-1:0]        req_even,
  input  logic [NUM_IN-1:0]        req_odd,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  output logic [NUM_IN-1:0]        clear,
  input  logic                     ro,
  output logic                     so,
  output logic [DATA_W-1:0]        data_out,
  output logic [1:0]               empty
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [1:0]             full_q, full_d;
  logic [1:0][PTR_W-1:0]  ptr_q, ptr_d;
  logic [1:0][DATA_W-1:0] vbuf_q, vbuf_d;
  logic                   so_q, so_d;
  logic [DATA_W-1:0]      dout_q, dout_d;

  logic                   ph_int, ph_ext;
  logic [NUM_IN-1:0]      req_sel, gnt;
  logic                   any_req;
  logic [PTR_W-1:0]       gnt_idx, ptr_nxt;
  logic [DATA_W-1:0]      sel_flit;
  logic                   load_en, drain_en;

  assign ph_int  = polarity;
  assign ph_ext  = ~polarity;
  assign req_sel = (polarity == VC_ODD) ? req_odd : req_even;

  rr_arb_n #(.NUM_IN(NUM_IN)) u_arb (
    .req_i (req_sel),
    .ptr_i (ptr_q[ph_int]),
    .gnt_o (gnt),
    .any_o (any_req),
    .idx_o (gnt_idx)
  );

  // Gating with reset keeps clear quiet while the block is held in reset.
  assign load_en  = reset & ~full_q[ph_int] & any_req;
  assign drain_en = full_q[ph_ext] & ro;
  assign clear    = load_en ? gnt : '0;

  always_comb begin
    sel_flit = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) sel_flit = data_in[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    if (int'(gnt_idx) == NUM_IN - 1) ptr_nxt = '0;
    else                             ptr_nxt = gnt_idx + PTR_W'(1);
  end

  always_comb begin
    full_d = full_q;
    ptr_d  = ptr_q;
    vbuf_d = vbuf_q;
    dout_d = dout_q;
    so_d   = drain_en;
    if (load_en) begin
      vbuf_d[ph_int] = sel_flit;
      full_d[ph_int] = 1'b1;
      ptr_d[ph_int]  = ptr_nxt;
    end
    if (drain_en) begin
      dout_d         = vbuf_q[ph_ext];
      full_d[ph_ext] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      full_q <= '0;
      ptr_q  <= '0;
      vbuf_q <= '0;
      so_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      full_q <= full_d;
      ptr_q  <= ptr_d;
      vbuf_q <= vbuf_d;
      so_q   <= so_d;
      dout_q <= dout_d;
    end
  end

  assign so       = so_q;
  assign data_out = dout_q;
  assign empty    = ~full_q;

endmodule

// File: tb/tb_vc_output_ctrl.sv
// Scoreboard bench for vc_output_ctrl: a behavioural model predicts clear and link flits.
// A separate monitor checks the link outputs and buffer status against that model.
module tb_vc_output_ctrl;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           polarity = 1'b0;
  logic           ro = 1'b0;
  logic [N-1:0]   req_even = '0, req_odd = '0, clear;
  logic [N*W-1:0] data_in = '0;
  logic           so;
  logic [W-1:0]   data_out;
  logic [1:0]     empty;

  vc_output_ctrl #(.NUM_IN(N), .DATA_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .req_even (req_even),
    .req_odd  (req_odd),
    .data_in  (data_in),
    .clear    (clear),
    .ro       (ro),
    .so       (so),
    .data_out (data_out),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each VC buffer holds one flit or nothing.
  logic [W-1:0] mbuf [2];
  bit           mfull [2] = '{1'b0, 1'b0};
  int           mptr [2] = '{0, 0};
  logic [W-1:0] mdout = '0;
  logic [W-1:0] exp_q [$];
  logic [N-1:0] obs_clr;
  int           last_g;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [N*W-1:0] rnd();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = {$urandom, $urandom};
    return v;
  endfunction

  // One clock cycle: drive inputs, predict, compare clear, advance to the next negedge.
  task automatic step(input bit rst, input logic [N-1:0] re, input logic [N-1:0] rq,
                      input bit r, input logic [N*W-1:0] d);
    logic [N-1:0] rs;
    logic [N-1:0] ec;
    int           g;
    bit           p;
    reset = rst; req_even = re; req_odd = rq; ro = r; data_in = d;
    #1;
    p = polarity;
    ec = '0;
    last_g = -1;
    if (!rst) begin
      mfull[0] = 0; mfull[1] = 0; mptr[0] = 0; mptr[1] = 0; mdout = '0;
    end else begin
      if (mfull[!p] && r) begin
        exp_q.push_back(mbuf[!p]);
        mdout = mbuf[!p];
        mfull[!p] = 0;
      end
      rs = p ? rq : re;
      if (!mfull[p] && rs != 0) begin
        g = mptr[p];
        for (int k = 0; k < N; k++) if (!rs[g]) g = (g + 1) % N;
        ec[g] = 1'b1;
        mbuf[p] = d[g*W +: W];
        mfull[p] = 1;
        mptr[p] = (g + 1) % N;
        last_g = g;
      end
    end
    obs_clr = clear;
    chk("clear", clear, ec);
    @(negedge clk);
    polarity = ~polarity;
  endtask

  task automatic align(input bit ph);
    if (polarity != ph) step(1, '0, '0, 1, rnd());
  endtask

  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    chk("empty", empty, {~mfull[1], ~mfull[0]});
    chk("data_out", data_out, mdout);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("so_high", so, 1);
      chk("flit", data_out, e);
    end else begin
      chk("so_low", so, 0);
    end
  end

  initial begin
    int           grants [$];
    int           cnt;
    logic [N*W-1:0] d;
    logic [W-1:0] saved;
    bit           ph;

    // Reset and idle
    step(0, '0, '0, 0, '0);
    step(0, '0, '0, 0, '0);
    for (int i = 0; i < 6; i++) step(1, '0, '0, 1, rnd());
    chk("idle_empty", empty, 2'b11);
    chk("idle_so", so, 0);
    chk("idle_dout", data_out, 0);

    // Single request on input 2, even VC
    align(0);
    d = '0;
    d[2*W +: W] = 64'hA5;
    step(1, 4'b0100, '0, 1, d);
    chk("single_clear", obs_clr, 4'b0100);
    step(1, '0, '0, 1, rnd());
    chk("single_so", so, 1);
    chk("single_dout", data_out, 64'hA5);
    chk("single_empty", empty, 2'b11);

    // Fairness on the odd VC
    step(0, '0, '0, 0, '0);
    step(0, '0, '0, 0, '0);
    for (int i = 0; i < 12; i++) begin
      ph = polarity;
      step(1, '0, 4'hF, 1, rnd());
      if (ph && obs_clr != 0) grants.push_back(last_g);
    end
    chk("fair_count", grants.size(), 6);
    if (grants.size() >= 5) begin
      chk("fair_g0", grants[0], 0);
      chk("fair_g1", grants[1], 1);
      chk("fair_g2", grants[2], 2);
      chk("fair_g3", grants[3], 3);
      chk("fair_wrap", grants[4], 0);
    end

    // Backpressure on the even VC
    step(0, '0, '0, 0, '0);
    step(0, '0, '0, 0, '0);
    align(0);
    d = rnd();
    saved = d[0 +: W];
    step(1, 4'b0001, '0, 0, d);
    for (int i = 0; i < 6; i++) begin
      ph = polarity;
      step(1, 4'hF, '0, 0, rnd());
      chk("bp_so", so, 0);
      chk("bp_empty0", empty[0], 0);
      if (!ph) chk("bp_clear", obs_clr, 0);
    end
    step(1, '0, '0, 1, rnd());
    step(1, '0, '0, 1, rnd());
    chk("bp_dout", data_out, saved);

    // Interleaved VCs at full rate
    step(0, '0, '0, 0, '0);
    step(0, '0, '0, 0, '0);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      step(1, 4'hF, 4'hF, 1, rnd());
      if (i >= 3 && so) cnt++;
    end
    chk("interleave_so", cnt, 21);

    // Reset with both buffers full
    step(0, '0, '0, 0, '0);
    step(0, '0, '0, 0, '0);
    step(1, 4'hF, 4'hF, 0, rnd());
    step(1, 4'hF, 4'hF, 0, rnd());
    chk("pre_rst_empty", empty, 2'b00);
    step(0, 4'hF, 4'hF, 1, rnd());
    chk("rst_clear", obs_clr, 0);
    chk("rst_empty", empty, 2'b11);
    chk("rst_so", so, 0);
    align(0);
    step(1, 4'hF, '0, 1, rnd());
    chk("rst_first_grant", obs_clr, 4'b0001);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), N'($urandom), N'($urandom),
           ($urandom_range(0, 3) != 0), rnd());
    end

    for (int i = 0; i < 3; i++) step(1, '0, '0, 1, rnd());
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_output_ctrl.md
# vc_output_ctrl

Parametrised output-port controller for the mesh router: arbitrates `NUM_IN` input buffers onto one outgoing link, with two single-entry virtual-channel (VC) buffers (even/odd) that alternate roles on the router `polarity` bit. It supersedes the fixed 4-input, VC-unaware output control. Per-VC round-robin fairness, per-VC empty status and a registered link interface are new. One instance sits at each router output (N, S, E, W, PE).

## Interface
Parameters:
- `NUM_IN`, default 4: number of requesting input ports; legal values 1..8.
- `DATA_W`, default 64: flit width in bits.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low. `reset==0` sampled at a rising edge resets the block.
- `polarity`  in  1: router phase bit. It toggles every cycle.
- `req_even`  in  `NUM_IN`: bit i means input i holds an even-VC flit destined here.
- `req_odd`  in  `NUM_IN`: bit i means input i holds an odd-VC flit destined here.
- `data_in`  in  `NUM_IN*DATA_W`: input i flit on bits `[i*DATA_W +: DATA_W]`.
- `clear`  out  `NUM_IN`: one-hot grant pulse. Input i frees its selected-VC buffer at this edge.
- `ro`  in  1: downstream ready for the VC currently on the link.
- `so`  out  1: registered send strobe.
- `data_out`  out  `DATA_W`: registered flit.
- `empty`  out  2: bit 0 is even-VC buffer empty; bit 1 is odd-VC buffer empty.

## Operation
- Phase p = `polarity`:
  - Internal side loads VC p.
  - External side drains VC ~p.
  - The two sides never touch the same buffer in one cycle.
- Load, in a cycle with phase p:
  - Condition: `vbuf[p]` is empty and `req_p != 0`.
  - A round-robin pick over `req_p` starts at `ptr[p]`. It selects input g.
  - `clear[g]=1` for that cycle, combinationally. All other `clear` bits are 0.
  - At the edge: `vbuf[p] <= data_in[g]`, and the buffer is marked full.
  - At the same edge: `ptr[p] <= (g+1) mod NUM_IN`.
- No load when `vbuf[p]` is full. In that case `clear` is all zero and `ptr[p]` holds.
- Drain, in a cycle with phase p:
  - Condition: `vbuf[~p]` is full and `ro=1`.
  - At the edge: `data_out <= vbuf[~p]`, `so <= 1`, and `vbuf[~p]` is marked empty.
  - Otherwise `so <= 0` and `data_out` holds its last value.
- `ptr[0]` and `ptr[1]` are independent.
- `empty` reflects the registered buffer flags. It never looks ahead.
- Reset:
  - `so=0`, `data_out=0`, `empty=2'b11`.
  - `ptr[0]=ptr[1]=0`.
  - `clear=0` while `reset==0`.
  - Reset mid-packet discards buffered flits. No `clear` is issued for them.

## Timing
- Input-to-link latency: minimum 2 cycles.
  - Load at edge t, in phase p.
  - Drain decision in cycle t+1, phase ~p, so the buffer is now on the external side.
  - `so`/`data_out` are valid in cycle t+2.
- Throughput per VC: one flit per 2 cycles. The aggregate link rate is 1 flit/cycle when both VCs are busy.
- `clear` is combinational from `req_*`, `polarity`, the buffer flags and `ptr`. It has no path from `ro`.
- Simultaneous load of `vbuf[p]` and drain of `vbuf[~p]` in the same cycle is normal operation.
- `ro=0`: the flit stays in `vbuf[~p]`. Retry happens two cycles later, at the next matching phase. Loads into that VC stall until the flit drains.
- `NUM_IN=1`: the pointer is constant 0. The arbiter degenerates to a gate.
- Round-robin wrap: with `ptr=NUM_IN-1` and a grant to input `NUM_IN-1`, the next `ptr` is 0.

## Structure
- Shared `router_pkg`:
  - `FLIT_W` (64), `VC_EVEN=1'b0`, `VC_ODD=1'b1`.
  - `typedef logic [FLIT_W-1:0] flit_t`.
- Sub-module `rr_arb_n`, parametrised by `NUM_IN`:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, any-grant flag, encoded index.
  - Purely combinational.
  - Instantiated once. Its request and pointer are muxed by `polarity`.
- Top level holds two VC buffers plus flags, two pointers, and the registered link outputs.

## Test plan
- Reset, then `polarity` toggling with no requests:
  - `so=0`, `data_out=0`, `empty=2'b11`, `clear=0` throughout.
- Single request, `NUM_IN=4`:
  - `req_even=4'b0100` with `data_in[2]=64'hA5`, presented in a `polarity=0` cycle, with `ro=1`.
  - `clear=4'b0100` that cycle.
  - `so=1`, `data_out=64'hA5` two cycles later.
  - `empty` returns to `2'b11`.
- Fairness:
  - `req_odd=4'b1111` held.
  - Grants go to 0, 1, 2, 3, 0 on successive odd loads.
  - `ptr[1]` wraps from 3 to 0.
- Backpressure:
  - Even flit buffered, `ro=0` for 6 cycles.
  - `so` stays 0, `empty[0]=0`, no further `clear` for even requests.
  - After `ro=1` in a drain phase, `so=1` with the original data.
- Interleaved VCs:
  - Even and odd requests every cycle, `ro=1`.
  - `so=1` every cycle after the fill latency.
  - Output flits alternate VC.
- Mid-operation reset:
  - `reset=0` with both buffers full.
  - Next cycle: `empty=2'b11`, `so=0`, `clear=0`.
  - After release, the first grant goes to input 0.
